accel_attitude_seq: RTL and testbench
=====================================

# accel_attitude_seq

Upstream sequencer for `cordic_angle`. It averages raw accelerometer samples, removes per-axis calibration offsets, and drives two `cordic_angle` runs: pitch = atan2(ax, √(ay²+az²)), then roll = atan2(ay, √(ax²+az²)). It publishes the pitch/roll pair with a one-cycle valid strobe to the attitude filter downstream.

## Interface
Parameters:
- `AVG_LOG2`, default 2: number of samples averaged is 2^AVG_LOG2. Legal range 0..6.
- `TIMEOUT`, default 4095: maximum cycles to wait for `cdra_done` per run before aborting.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `acc_valid`  in  1  one-cycle strobe; `acc_x/y/z` valid.
- `acc_x`, `acc_y`, `acc_z`  in  16 signed  raw accelerometer sample.
- `ofs_x`, `ofs_y`, `ofs_z`  in  16 signed  static calibration offsets, subtracted from each sample.
- `cdra_start`  out  1  one-cycle start pulse to `cordic_angle`.
- `cdra_x`, `cdra_y`, `cdra_z`  out  16 signed  operands to `cordic_angle`; held stable from start until done.
- `cdra_done`  in  1  one-cycle completion strobe from `cordic_angle`.
- `cdra_angle`  in  16 signed  result, valid while `cdra_done`=1.
- `pitch`, `roll`  out  16 signed  latest angles; held between updates.
- `att_valid`  out  1  one-cycle strobe; new `pitch`/`roll` pair.
- `busy`  out  1  high in every state except ACC.
- `err_timeout`  out  1  one-cycle pulse on a CORDIC timeout abort.
- `overrun`  out  1  sticky; a sample arrived while not in ACC. Cleared only by `rst`.

## Operation
- Reset: every output is 0. Accumulators and counters are 0. State is ACC.
- Per-sample difference: d = acc − ofs, computed in 17 bits signed with no wrap. Accumulators are 17+AVG_LOG2 bits signed.
- ACC: each `acc_valid` adds d to the three accumulators and increments the sample count.
  - On the 2^AVG_LOG2-th sample: avg = sum >>> AVG_LOG2 (arithmetic, floor), saturated to [−32768, 32767].
  - Results go to registers ax/ay/az. Accumulators and count clear. Next state is P_START.
- P_START: drive cdra_x=ax, cdra_y=ay, cdra_z=az. Pulse `cdra_start` for 1 cycle. Go to P_WAIT.
- P_WAIT: on `cdra_done`, `pitch`_pending ← `cdra_angle`, then go to GAP.
- GAP: exactly one idle cycle, so the CORDIC returns to its idle state. Then go to R_START.
- R_START: drive cdra_x=ay, cdra_y=ax, cdra_z=az. Pulse `cdra_start`. Go to R_WAIT.
- R_WAIT: on `cdra_done`, `roll` ← `cdra_angle` and `pitch` ← pitch_pending, updated in the same cycle. Go to OUT.
- OUT: `att_valid`=1 for this cycle only. Go to ACC.
- `pitch` and `roll` never update separately. A consumer sampling on `att_valid` always sees a coherent pair.
- Timeout: in P_WAIT or R_WAIT a wait counter starts at 0 on entry and increments each cycle.
  - When it reaches TIMEOUT without `cdra_done`: pulse `err_timeout` and return to ACC.
  - No `att_valid`. `pitch`/`roll` keep their old values. The pending pitch is discarded.
- `cdra_done` outside P_WAIT/R_WAIT is ignored.
- `acc_valid` outside ACC: sample dropped, `overrun` ← 1.
- `rst` mid-operation: next cycle is the reset state regardless of CORDIC activity. A late `cdra_done` is then ignored.

## Timing
- `cdra_start` is high for exactly 1 cycle, in the cycle after entering P_START/R_START. Operands are stable from that cycle until the state leaves the matching WAIT.
- Last averaged sample at edge n: `cdra_start` (pitch) high in cycle n+1.
- Pitch `cdra_done` sampled at edge m: GAP is cycle m+1, roll `cdra_start` is high in cycle m+2.
- Roll `cdra_done` sampled at edge k: `pitch`/`roll` updated and `att_valid`=1 in cycle k+1.
- Total block overhead excluding CORDIC time: 4 cycles (start pitch, gap, start roll, out).
- Minimum sample spacing: 1 cycle (back-to-back `acc_valid` in ACC all accepted).

## Test plan
- Level, AVG_LOG2=2, ofs=0, four samples (0, 0, 16384); CORDIC model returns 100 then −50.
  -> operands (0, 0, 16384) then (0, 0, 16384). `pitch`=100, `roll`=−50, `att_valid` high 1 cycle, `cdra_start` pulses exactly twice.
- Offset/swap: 4× (1000, −300, 8000) with ofs (200, 100, 0).
  -> pitch run (800, −400, 8000); roll run (−400, 800, 8000).
- Rounding/saturation:
  - Samples x = −1, −1, −1, 0 -> cdra_x = −1.
  - acc_x=32767 with ofs_x=−32768 ×4 -> cdra_x = 32767.
  - acc_x=−32768 with ofs_x=32767 -> cdra_x = −32768.
- Timeout: TIMEOUT=15, model never asserts done.
  -> `err_timeout` pulses 15 cycles after P_WAIT entry; no `att_valid`; prior `pitch`/`roll` unchanged. The next 4 samples start a fresh pitch run.
- Overrun/back-to-back: 4 samples on consecutive cycles, then a 5th while `busy`=1.
  -> run starts; `overrun` goes to 1 and stays 1 after `att_valid`. The 5th sample does not enter the next average.
- Reset mid-run: `rst` in R_WAIT, then `cdra_done` 3 cycles later.
  -> all outputs 0, state ACC, no `att_valid`, done ignored.

Source files
------------

// File: rtl/accel_attitude_seq.sv
// Averages accelerometer samples, removes offsets, sequences pitch/roll cordic_angle runs.
// Latency: 4 cycles of overhead on top of two CORDIC runs (start, gap, start, out).
// No backpressure: samples arriving while busy are dropped and flagged on sticky overrun.
module accel_attitude_seq #(
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT  = 4095
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               acc_valid,
   input  logic signed [15:0] acc_x,
   input  logic signed [15:0] acc_y,
   input  logic signed [15:0] acc_z,
   input  logic signed [15:0] ofs_x,
   input  logic signed [15:0] ofs_y,
   input  logic signed [15:0] ofs_z,
   output logic               cdra_start,
   output logic signed [15:0] cdra_x,
   output logic signed [15:0] cdra_y,
   output logic signed [15:0] cdra_z,
   input  logic               cdra_done,
   input  logic signed [15:0] cdra_angle,
   output logic signed [15:0] pitch,
   output logic signed [15:0] roll,
   output logic               att_valid,
   output logic               busy,
   output logic               err_timeout,
   output logic               overrun
);

   localparam int AW = 17 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
   localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
   localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

   typedef enum logic [2:0] {
      ACC, P_START, P_WAIT, GAP, R_START, R_WAIT, OUT
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [TW-1:0]        wcnt;
   logic signed [AW-1:0] sum_x, sum_y, sum_z;
   logic signed [15:0]   ax, ay, az;
   logic signed [15:0]   pitch_pend;

   logic signed [16:0]   d_x, d_y, d_z;
   logic signed [AW-1:0] sum_nx_x, sum_nx_y, sum_nx_z;
   logic signed [AW-1:0] avg_x, avg_y, avg_z;

   // Clamp the averaged value into the 16-bit operand range.
   function automatic logic signed [15:0] sat16(input logic signed [AW-1:0] v);
      if (v > SAT_MAX)
         return 16'sh7fff;
      else if (v < SAT_MIN)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

   // Offset removal in 17 bits so full-scale differences cannot wrap, then running sum and average.
   always_comb begin
      d_x      = {acc_x[15], acc_x} - {ofs_x[15], ofs_x};
      d_y      = {acc_y[15], acc_y} - {ofs_y[15], ofs_y};
      d_z      = {acc_z[15], acc_z} - {ofs_z[15], ofs_z};
      sum_nx_x = sum_x + AW'(d_x);
      sum_nx_y = sum_y + AW'(d_y);
      sum_nx_z = sum_z + AW'(d_z);
      avg_x    = sum_nx_x >>> AVG_LOG2;
      avg_y    = sum_nx_y >>> AVG_LOG2;
      avg_z    = sum_nx_z >>> AVG_LOG2;
   end

   assign busy = (state != ACC);

   // Sequencer: accumulate, run pitch then roll, publish the pair together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ACC;
         cnt         <= '0;
         wcnt        <= '0;
         sum_x       <= '0;
         sum_y       <= '0;
         sum_z       <= '0;
         ax          <= '0;
         ay          <= '0;
         az          <= '0;
         pitch_pend  <= '0;
         cdra_start  <= 1'b0;
         cdra_x      <= '0;
         cdra_y      <= '0;
         cdra_z      <= '0;
         pitch       <= '0;
         roll        <= '0;
         att_valid   <= 1'b0;
         err_timeout <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         cdra_start  <= 1'b0;
         att_valid   <= 1'b0;
         err_timeout <= 1'b0;
         if (acc_valid && state != ACC)
            overrun <= 1'b1;
         case (state)
            ACC: begin
               if (acc_valid) begin
                  if (cnt == CNT_LAST) begin
                     ax         <= sat16(avg_x);
                     ay         <= sat16(avg_y);
                     az         <= sat16(avg_z);
                     cdra_x     <= sat16(avg_x);
                     cdra_y     <= sat16(avg_y);
                     cdra_z     <= sat16(avg_z);
                     cdra_start <= 1'b1;
                     cnt        <= '0;
                     sum_x      <= '0;
                     sum_y      <= '0;
                     sum_z      <= '0;
                     state      <= P_START;
                  end else begin
                     sum_x <= sum_nx_x;
                     sum_y <= sum_nx_y;
                     sum_z <= sum_nx_z;
                     cnt   <= cnt + 1'b1;
                  end
               end
            end
            P_START: begin
               wcnt  <= '0;
               state <= P_WAIT;
            end
            P_WAIT: begin
               if (cdra_done) begin
                  pitch_pend <= cdra_angle;
                  state      <= GAP;
               end else if (wcnt == WAIT_LAST) begin
                  err_timeout <= 1'b1;
                  state       <= ACC;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            GAP: begin
               // Roll reuses the pitch datapath with x and y swapped.
               cdra_x     <= ay;
               cdra_y     <= ax;
               cdra_z     <= az;
               cdra_start <= 1'b1;
               state      <= R_START;
            end
            R_START: begin
               wcnt  <= '0;
               state <= R_WAIT;
            end
            R_WAIT: begin
               if (cdra_done) begin
                  roll      <= cdra_angle;
                  pitch     <= pitch_pend;
                  att_valid <= 1'b1;
                  state     <= OUT;
               end else if (wcnt == WAIT_LAST) begin
                  err_timeout <= 1'b1;
                  pitch_pend  <= '0;
                  state       <= ACC;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            OUT: begin
               state <= ACC;
            end
            default: begin
               state <= ACC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accel_attitude_seq.sv
// Directed bench for accel_attitude_seq: table of averaging vectors plus timeout,
// overrun and mid-run reset sequences. The CORDIC is modelled inline by the
// stimulus thread, which pulses cdra_done with a chosen angle.
module tb_accel_attitude_seq;

   logic               clk = 1'b0;
   logic               rst;
   logic               acc_valid;
   logic signed [15:0] acc_x, acc_y, acc_z;
   logic signed [15:0] ofs_x, ofs_y, ofs_z;
   logic               cdra_start;
   logic signed [15:0] cdra_x, cdra_y, cdra_z;
   logic               cdra_done;
   logic signed [15:0] cdra_angle;
   logic signed [15:0] pitch, roll;
   logic               att_valid, busy, err_timeout, overrun;

   always #5 clk = ~clk;

   accel_attitude_seq #(.AVG_LOG2(2), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .acc_valid(acc_valid),
      .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
      .ofs_x(ofs_x), .ofs_y(ofs_y), .ofs_z(ofs_z),
      .cdra_start(cdra_start), .cdra_x(cdra_x), .cdra_y(cdra_y), .cdra_z(cdra_z),
      .cdra_done(cdra_done), .cdra_angle(cdra_angle),
      .pitch(pitch), .roll(roll), .att_valid(att_valid), .busy(busy),
      .err_timeout(err_timeout), .overrun(overrun)
   );

   typedef struct packed {
      logic [3:0][15:0] sx, sy, sz;
      logic [15:0]      ox, oy, oz;
      logic [15:0]      pa, ra;
      logic [15:0]      ex, ey, ez;
      logic             inj;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   prev_p = 0;
   int   prev_r = 0;

   function automatic logic [15:0] s16(input int v);
      return v[15:0];
   endfunction

   function automatic logic [63:0] rep4(input int v);
      return {4{s16(v)}};
   endfunction

   function automatic int sv(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int i, input logic [63:0] x, input logic [63:0] y, input logic [63:0] z,
                          input int ox, input int oy, input int oz, input int pa, input int ra,
                          input int ex, input int ey, input int ez, input bit inj);
      vecs[i].sx = x; vecs[i].sy = y; vecs[i].sz = z;
      vecs[i].ox = s16(ox); vecs[i].oy = s16(oy); vecs[i].oz = s16(oz);
      vecs[i].pa = s16(pa); vecs[i].ra = s16(ra);
      vecs[i].ex = s16(ex); vecs[i].ey = s16(ey); vecs[i].ez = s16(ez);
      vecs[i].inj = inj;
   endtask

   // Four back-to-back samples; returns at the falling edge of the first cdra_start cycle.
   task automatic feed(input vec_t v);
      ofs_x = v.ox; ofs_y = v.oy; ofs_z = v.oz;
      for (int i = 0; i < 4; i++) begin
         acc_valid = 1'b1;
         acc_x = v.sx[i]; acc_y = v.sy[i]; acc_z = v.sz[i];
         @(negedge clk);
      end
      acc_valid = 1'b0;
      acc_x = '0; acc_y = '0; acc_z = '0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      if (v.inj) chk({tag, " overrun_pre"}, int'(overrun), 0);
      feed(v);
      chk({tag, " p_start"}, int'(cdra_start), 1);
      chk({tag, " p_x"}, sv(cdra_x), sv(v.ex));
      chk({tag, " p_y"}, sv(cdra_y), sv(v.ey));
      chk({tag, " p_z"}, sv(cdra_z), sv(v.ez));
      chk({tag, " busy"}, int'(busy), 1);
      @(negedge clk);
      chk({tag, " p_start_1cyc"}, int'(cdra_start), 0);
      if (v.inj) begin
         acc_valid = 1'b1;
         acc_x = 16'sd30000; acc_y = 16'sd30000; acc_z = -16'sd30000;
      end
      @(negedge clk);
      acc_valid = 1'b0;
      acc_x = '0; acc_y = '0; acc_z = '0;
      chk({tag, " p_x_hold"}, sv(cdra_x), sv(v.ex));
      cdra_done = 1'b1; cdra_angle = v.pa;
      @(negedge clk);
      cdra_done = 1'b0; cdra_angle = '0;
      chk({tag, " gap_start"}, int'(cdra_start), 0);
      chk({tag, " gap_pitch_old"}, sv(pitch), prev_p);
      chk({tag, " gap_att"}, int'(att_valid), 0);
      @(negedge clk);
      chk({tag, " r_start"}, int'(cdra_start), 1);
      chk({tag, " r_x"}, sv(cdra_x), sv(v.ey));
      chk({tag, " r_y"}, sv(cdra_y), sv(v.ex));
      chk({tag, " r_z"}, sv(cdra_z), sv(v.ez));
      @(negedge clk);
      chk({tag, " r_start_1cyc"}, int'(cdra_start), 0);
      chk({tag, " roll_old"}, sv(roll), prev_r);
      cdra_done = 1'b1; cdra_angle = v.ra;
      @(negedge clk);
      cdra_done = 1'b0; cdra_angle = '0;
      chk({tag, " att_valid"}, int'(att_valid), 1);
      chk({tag, " pitch"}, sv(pitch), sv(v.pa));
      chk({tag, " roll"}, sv(roll), sv(v.ra));
      if (v.inj) chk({tag, " overrun_set"}, int'(overrun), 1);
      @(negedge clk);
      chk({tag, " att_pulse"}, int'(att_valid), 0);
      chk({tag, " idle"}, int'(busy), 0);
      chk({tag, " pitch_hold"}, sv(pitch), sv(v.pa));
      if (v.inj) chk({tag, " overrun_sticky"}, int'(overrun), 1);
      prev_p = sv(v.pa);
      prev_r = sv(v.ra);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " pitch0"}, sv(pitch), 0);
      chk({tag, " roll0"}, sv(roll), 0);
      chk({tag, " att0"}, int'(att_valid), 0);
      chk({tag, " busy0"}, int'(busy), 0);
      chk({tag, " err0"}, int'(err_timeout), 0);
      chk({tag, " ovr0"}, int'(overrun), 0);
      chk({tag, " start0"}, int'(cdra_start), 0);
      chk({tag, " cx0"}, sv(cdra_x), 0);
      chk({tag, " cy0"}, sv(cdra_y), 0);
      chk({tag, " cz0"}, sv(cdra_z), 0);
   endtask

   initial begin
      vec_t tv;
      int   found;
      bit   bad;

      set_vec(0, rep4(0), rep4(0), rep4(16384), 0, 0, 0, 100, -50, 0, 0, 16384, 1'b0);
      set_vec(1, rep4(1000), rep4(-300), rep4(8000), 200, 100, 0, 1234, -777, 800, -400, 8000, 1'b1);
      set_vec(2, {s16(-1), s16(-1), s16(-1), s16(0)}, {s16(5), s16(6), s16(7), s16(8)},
              {s16(-5), s16(-6), s16(-7), s16(-8)}, 0, 0, 0, -20000, 32767, -1, 6, -7, 1'b0);
      set_vec(3, rep4(32767), rep4(-32768), rep4(100), -32768, 32767, 0, 7, 8, 32767, -32768, 100, 1'b0);
      set_vec(4, {s16(10), s16(20), s16(30), s16(40)}, rep4(0), {s16(3), s16(0), s16(0), s16(0)},
              -5, 0, 0, -1, 1, 30, 0, 0, 1'b0);
      set_vec(5, rep4(-100), rep4(50), rep4(-16000), 0, 0, 0, 4000, -4000, -100, 50, -16000, 1'b0);
      set_vec(6, rep4(3), rep4(-3), rep4(9), 1, 1, 1, 11, 22, 2, -4, 8, 1'b0);

      rst = 1'b1; acc_valid = 1'b0; cdra_done = 1'b0; cdra_angle = '0;
      acc_x = '0; acc_y = '0; acc_z = '0; ofs_x = '0; ofs_y = '0; ofs_z = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++)
         run_vec(vecs[i], $sformatf("v%0d", i));

      // CORDIC never answers: abort after the wait budget, outputs untouched.
      tv = vecs[0];
      tv.sx = rep4(1); tv.sy = rep4(2); tv.sz = rep4(3);
      feed(tv);
      chk("tmo p_start", int'(cdra_start), 1);
      chk("tmo p_x", sv(cdra_x), 1);
      found = 0;
      bad = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (att_valid) bad = 1'b1;
         if (err_timeout) begin
            found = j;
            break;
         end
      end
      chk("tmo cycles", found, 16);
      chk("tmo no_att", int'(bad), 0);
      chk("tmo idle", int'(busy), 0);
      chk("tmo pitch_kept", sv(pitch), prev_p);
      chk("tmo roll_kept", sv(roll), prev_r);
      @(negedge clk);
      chk("tmo err_pulse", int'(err_timeout), 0);
      run_vec(vecs[5], "v5_after_tmo");

      // Reset while waiting for the roll result; the late done must be ignored.
      feed(vecs[6]);
      @(negedge clk);
      cdra_done = 1'b1; cdra_angle = 16'sd111;
      @(negedge clk);
      cdra_done = 1'b0; cdra_angle = '0;
      @(negedge clk);
      chk("rstmid r_start", int'(cdra_start), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_zero("rstmid");
      repeat (2) @(negedge clk);
      cdra_done = 1'b1; cdra_angle = 16'sd999;
      @(negedge clk);
      cdra_done = 1'b0; cdra_angle = '0;
      bad = 1'b0;
      for (int j = 0; j < 3; j++) begin
         if (att_valid || busy || cdra_start) bad = 1'b1;
         @(negedge clk);
      end
      chk("rstmid late_done_ignored", int'(bad), 0);
      chk("rstmid pitch_still0", sv(pitch), 0);
      chk("rstmid roll_still0", sv(roll), 0);
      prev_p = 0;
      prev_r = 0;
      run_vec(vecs[6], "v6_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
